ntt_output_streamer: RTL

- Sink side of the pipelined NTT/iNTT block. Captures full N-wide frames that arrive in bit-reversed order with a one-cycle frame-valid strobe and no backpressure.
- Reorders each frame to natural order and stores it in a two-frame ping-pong buffer.
- Emits coefficients one per beat on a valid/ready stream toward the downstream coefficient memory or host interface.
- Frames that arrive while both buffers are full are dropped and reported.

---
 rtl/ntt_pkg.sv | 21 ++
 rtl/ntt_frame_pingpong.sv | 62 ++++++
 rtl/ntt_output_streamer.sv | 77 +++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: coefficient/frame types and the bit-reversal index map
// used by both the NTT core and its output streamer.
package ntt_pkg;

   localparam int NTT_W = 32;
   localparam int NTT_N = 4;

   typedef logic [NTT_W-1:0] coeff_t;
   typedef coeff_t frame_t [0:NTT_N-1];

   // Reverses the low log2_n bits of idx.
   function automatic int unsigned bit_reverse(input int unsigned idx, input int unsigned log2_n);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < log2_n; b++) begin
         if (idx[b]) r = r | (32'd1 << (log2_n - 1 - b));
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_frame_pingpong.sv
// Two-slot frame store: captures a bit-reversed frame in natural order on push,
// presents one coefficient of the read slot selected by the beat index.
module ntt_frame_pingpong
   import ntt_pkg::*;
#(
   parameter  int W      = 32,
   parameter  int N      = 4,
   localparam int LOG2_N = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              push_mode_i,
   input  logic [W-1:0]      push_data_i [0:N-1],
   input  logic              pop_i,
   input  logic [LOG2_N-1:0] rd_beat_i,
   output logic [W-1:0]      rd_coeff_o,
   output logic              rd_mode_o
);

   logic [W-1:0] frame_q [0:1][0:N-1];
   logic [W-1:0] frame_d [0:1][0:N-1];
   logic [1:0]   mode_q, mode_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;

   always_comb begin
      frame_d  = frame_q;
      mode_d   = mode_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // When full and popping, wr_ptr equals rd_ptr: the vacated slot is reused.
      if (push_i) begin
         for (int k = 0; k < N; k++) begin
            frame_d[wr_ptr_q][LOG2_N'(k)] = push_data_i[LOG2_N'(bit_reverse(k, LOG2_N))];
         end
         mode_d[wr_ptr_q] = push_mode_i;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_d = ~rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < N; k++) frame_q[p][k] <= '0;
         end
         mode_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         frame_q  <= frame_d;
         mode_q   <= mode_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign rd_coeff_o = frame_q[rd_ptr_q][rd_beat_i];
   assign rd_mode_o  = mode_q[rd_ptr_q];

endmodule

// File: rtl/ntt_output_streamer.sv
// NTT sink: buffers up to two reordered frames and streams them one coefficient
// per valid/ready beat; frames arriving while full are dropped and flagged.
module ntt_output_streamer
   import ntt_pkg::*;
#(
   parameter  int W      = 32,
   parameter  int N      = 4,
   localparam int LOG2_N = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_valid_in,
   input  logic              frame_mode_in,
   input  logic [W-1:0]      frame_data_in [0:N-1],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [LOG2_N-1:0] out_index,
   output logic              out_last,
   output logic              out_mode,
   output logic [1:0]        frames_pending,
   output logic              overflow,
   input  logic              clear_overflow
);

   localparam logic [LOG2_N-1:0] LAST_BEAT = LOG2_N'(N - 1);

   logic [LOG2_N-1:0] beat_q, beat_d;
   logic [1:0]        pending_q, pending_d;
   logic              ovf_q, ovf_d;
   logic              xfer, pop, push, drop;

   assign out_valid = (pending_q != 2'd0);
   assign xfer      = out_valid && out_ready;
   assign pop       = xfer && (beat_q == LAST_BEAT);
   assign push      = frame_valid_in && ((pending_q != 2'd2) || pop);
   assign drop      = frame_valid_in && !push;

   always_comb begin
      beat_d = beat_q;
      if (xfer) beat_d = pop ? '0 : beat_q + LOG2_N'(1);
      pending_d = pending_q + {1'b0, push} - {1'b0, pop};
      ovf_d     = ovf_q;
      if (clear_overflow) ovf_d = 1'b0;
      if (drop)           ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_q    <= '0;
         pending_q <= 2'd0;
         ovf_q     <= 1'b0;
      end else begin
         beat_q    <= beat_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   ntt_frame_pingpong #(.W(W), .N(N)) u_pingpong (
      .clk         (clk),
      .rst_n       (reset_n),
      .push_i      (push),
      .push_mode_i (frame_mode_in),
      .push_data_i (frame_data_in),
      .pop_i       (pop),
      .rd_beat_i   (beat_q),
      .rd_coeff_o  (out_data),
      .rd_mode_o   (out_mode)
   );

   assign out_index      = beat_q;
   assign out_last       = out_valid && (beat_q == LAST_BEAT);
   assign frames_pending = pending_q;
   assign overflow       = ovf_q;

endmodule
